// File: rtl/sid_rx.sv
// Receive-side student-ID reader: polls the UART over the rib bus, packs the ASCII digits it
// receives into BCD, and compares the result with the expected ID.
module sid_rx #(
  parameter logic [31:0]        UART_BASE = 32'h3000_0000,
  parameter int unsigned        DEPTH     = 10,
  parameter logic [4*DEPTH-1:0] EXP_BCD   = 40'h20233_10655,
  parameter logic [31:0]        TIMEOUT   = 32'd100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               done_o,
  output logic               busy_o,
  output logic [4*DEPTH-1:0] bcd_o,
  output logic [3:0]         cnt_o,
  output logic               match_o,
  output logic               err_o,
  output logic               rx_mem_req_o,
  output logic               rx_mem_we_o,
  output logic [31:0]        rx_mem_addr_o,
  output logic [31:0]        rx_mem_wdata_o,
  input  logic               rx_mem_gnt_i,
  input  logic [31:0]        rx_mem_rdata_i
);

  localparam int unsigned BcdW       = 4 * DEPTH;
  localparam logic [31:0] StatusAddr = UART_BASE + 32'd4;
  localparam logic [31:0] RxdataAddr = UART_BASE + 32'd16;
  localparam logic [3:0]  DepthCnt   = 4'(DEPTH);

  typedef enum logic [2:0] {StIdle, StPoll, StRead, StClear, StDone} state_e;

  state_e            state_q;
  logic [BcdW-1:0]   bcd_q;
  logic [3:0]        cnt_q;
  logic              err_q, match_q, done_q, term_q;
  logic              req_q, we_q;
  logic [31:0]       addr_q, wdata_q, tmo_q;

  logic [7:0] rx_byte;
  logic       is_digit, is_eol;
  logic       unused_rdata;

  assign rx_byte      = rx_mem_rdata_i[7:0];
  assign is_digit     = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign is_eol       = (rx_byte == 8'h0a) || (rx_byte == 8'h0d);
  assign unused_rdata = ^rx_mem_rdata_i[31:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      term_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            bcd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
            term_q  <= 1'b0;
            tmo_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= StatusAddr;
            state_q <= StPoll;
          end
        end
        StPoll: begin
          if (rx_mem_gnt_i && rx_mem_rdata_i[1]) begin
            tmo_q   <= '0;
            addr_q  <= RxdataAddr;
            state_q <= StRead;
          end else if (tmo_q + 32'd1 >= TIMEOUT) begin
            // Ungranted cycles count too, so a stalled bus also times out.
            tmo_q   <= tmo_q + 32'd1;
            err_q   <= 1'b1;
            match_q <= 1'b0;
            done_q  <= 1'b1;
            req_q   <= 1'b0;
            addr_q  <= '0;
            state_q <= StDone;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        StRead: begin
          if (rx_mem_gnt_i) begin
            if (is_digit) begin
              if (cnt_q < DepthCnt) begin
                bcd_q <= {bcd_q[BcdW-5:0], rx_byte[3:0]};
                cnt_q <= cnt_q + 4'd1;
              end
            end else if (is_eol) begin
              // A line end before any digit is a leftover from the previous line.
              if (cnt_q != 4'd0) term_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            we_q    <= 1'b1;
            addr_q  <= StatusAddr;
            wdata_q <= '0;
            state_q <= StClear;
          end
        end
        StClear: begin
          if (rx_mem_gnt_i) begin
            we_q <= 1'b0;
            if (term_q || (cnt_q == DepthCnt)) begin
              done_q  <= 1'b1;
              match_q <= !err_q && (cnt_q == DepthCnt) && (bcd_q == EXP_BCD);
              req_q   <= 1'b0;
              addr_q  <= '0;
              state_q <= StDone;
            end else begin
              state_q <= StPoll;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_o         = done_q;
  assign busy_o         = (state_q != StIdle);
  assign bcd_o          = bcd_q;
  assign cnt_o          = cnt_q;
  assign match_o        = match_q;
  assign err_o          = err_q;
  assign rx_mem_req_o   = req_q;
  assign rx_mem_we_o    = we_q;
  assign rx_mem_addr_o  = addr_q;
  assign rx_mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_sid_rx.sv
// Bench for sid_rx: a behavioural UART/rib slave feeds byte strings; results are checked
// against a string-level reference model.
module tb_sid_rx;

  localparam int unsigned DEPTH  = 10;
  localparam logic [39:0] EXP    = 40'h2023310655;
  localparam logic [31:0] STATUS = 32'h3000_0004;
  localparam logic [31:0] RXDATA = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        done_o, busy_o, match_o, err_o;
  logic [39:0] bcd_o;
  logic [3:0]  cnt_o;
  logic        req, we, gnt;
  logic [31:0] addr, wdata, rdata;

  always #5 clk = ~clk;

  sid_rx #(.TIMEOUT(32'd50)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .bcd_o         (bcd_o),
    .cnt_o         (cnt_o),
    .match_o       (match_o),
    .err_o         (err_o),
    .rx_mem_req_o  (req),
    .rx_mem_we_o   (we),
    .rx_mem_addr_o (addr),
    .rx_mem_wdata_o(wdata),
    .rx_mem_gnt_i  (gnt),
    .rx_mem_rdata_i(rdata)
  );

  // UART / bus slave model
  logic [7:0]  byte_mem [0:31];
  int unsigned n_bytes = 0;
  int unsigned rd_ptr = 0;
  int unsigned delay = 0;
  logic        avail = 1'b0;
  logic        load_req = 1'b0;
  int unsigned gnt_mode = 0;  // 0 random, 1 low, 2 high
  int unsigned n_wr = 0, n_bad_wr = 0, n_poll = 0, n_done = 0;
  int unsigned n_tests = 0, n_fail = 0;

  always_comb begin
    rdata = '0;
    if (addr == STATUS) rdata[1] = avail;
    else if (addr == RXDATA && rd_ptr < n_bytes) rdata[7:0] = byte_mem[rd_ptr];
  end

  initial gnt = 1'b0;
  always @(negedge clk) begin
    case (gnt_mode)
      1: gnt <= 1'b0;
      2: gnt <= 1'b1;
      default: gnt <= ($urandom_range(3) != 0);
    endcase
  end

  always @(posedge clk) begin
    if (load_req) begin
      rd_ptr <= 0;
      avail  <= 1'b0;
      delay  <= 0;
    end else if (req && gnt && we) begin
      if (addr == STATUS && wdata == 32'd0) n_wr <= n_wr + 1;
      else n_bad_wr <= n_bad_wr + 1;
      rd_ptr <= rd_ptr + 1;
      avail  <= 1'b0;
      delay  <= $urandom_range(3);
    end else if (!avail && rd_ptr < n_bytes) begin
      if (delay == 0) avail <= 1'b1;
      else delay <= delay - 1;
    end
    if (busy_o && req && !we && addr == STATUS) n_poll <= n_poll + 1;
    if (done_o) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit_bytes(input int unsigned n);
    n_bytes = n;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) byte_mem[i] = s[i];
    commit_bytes(s.len());
  endtask

  // String-level reference: what a reader of this byte stream should conclude.
  task automatic model(output logic [39:0] mb, output int unsigned mc, output bit me,
                       output bit mm, output int unsigned mu);
    longint unsigned v;
    bit fin;
    logic [7:0] b;
    v = 0; mc = 0; me = 0; mu = 0; fin = 0;
    for (int i = 0; i < n_bytes; i++) begin
      b = byte_mem[i];
      mu++;
      if (b >= 8'h30 && b <= 8'h39) begin
        v = ((v * 16) + longint'(b - 8'h30)) % (64'd1 << 40);
        mc++;
        if (mc == DEPTH) begin fin = 1; break; end
      end else if (b == 8'h0a || b == 8'h0d) begin
        if (mc > 0) begin fin = 1; break; end
      end else begin
        me = 1;
      end
    end
    if (!fin) me = 1;  // stream ran dry: the reader must time out
    mb = v[39:0];
    mm = !me && mc == DEPTH && mb == EXP;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned k;
    k = 0;
    while (!done_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done_o) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
  endtask

  task automatic check_result(input string tag, input int unsigned wr0, input int unsigned dn0);
    logic [39:0] mb;
    int unsigned mc, mu;
    bit me, mm;
    model(mb, mc, me, mm, mu);
    chk({tag, "_bcd"}, 64'(bcd_o), 64'(mb));
    chk({tag, "_cnt"}, 64'(cnt_o), 64'(mc));
    chk({tag, "_err"}, 64'(err_o), 64'(me));
    chk({tag, "_match"}, 64'(match_o), 64'(mm));
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, 64'({busy_o, done_o, req}), 64'd0);
    chk({tag, "_ndone"}, 64'(n_done - dn0), 64'd1);
    chk({tag, "_nwr"}, 64'(n_wr - wr0), 64'(mu));
  endtask

  task automatic run(input string tag);
    int unsigned wr0, dn0;
    wr0 = n_wr;
    dn0 = n_done;
    pulse_start();
    wait_done(tag);
    check_result(tag, wr0, dn0);
  endtask

  task automatic wait_bus(input string tag, input logic w, input logic [31:0] a);
    int unsigned k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(req && we == w && addr == a) && k < 2000);
    chk({tag, "_reached"}, 64'(req && we == w && addr == a), 64'd1);
  endtask

  initial begin
    int unsigned p0, wr0, dn0, bad0, len, r;

    #2;
    chk("rst_ctl", 64'({done_o, busy_o, match_o, err_o, req, we}), 64'd0);
    chk("rst_data", 64'({cnt_o, bcd_o}), 64'd0);
    chk("rst_bus", {addr, wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    load_str("2023310655");
    run("t1_golden");
    load_str("2023310654");
    run("t2_near");
    load_str("12\n");
    run("t3_short");
    load_str("20A23310655");
    run("t4_badchar");
    load_str("\r\n2023310655");
    run("t7_lead_eol");

    // Empty UART: exactly TIMEOUT poll cycles, then DONE.
    commit_bytes(0);
    p0 = n_poll;
    run("t5_timeout");
    chk("t5_polls", 64'(n_poll - p0), 64'd50);

    // Grant withheld in READ: request must hold steady, start while busy ignored.
    load_str("2023310655");
    gnt_mode = 2;
    wr0 = n_wr;
    dn0 = n_done;
    pulse_start();
    wait_bus("t6_read", 1'b0, RXDATA);
    gnt_mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      start_i = (i == 1);
      chk("t6_hold", 64'({req, we, addr}), 64'({1'b1, 1'b0, RXDATA}));
    end
    start_i = 1'b0;
    gnt_mode = 2;
    @(negedge clk);
    wait_done("t6_stall");
    check_result("t6_stall", wr0, dn0);

    // Reset asserted while a clear write is pending.
    load_str("2023310655");
    pulse_start();
    wait_bus("t6_clear", 1'b1, STATUS);
    gnt_mode = 1;
    bad0 = n_bad_wr;
    wr0 = n_wr;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_ctl", 64'({done_o, busy_o, match_o, err_o, req, we}), 64'd0);
    chk("t6_rst_data", 64'({cnt_o, bcd_o}), 64'd0);
    chk("t6_rst_bus", {addr, wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    gnt_mode = 0;
    repeat (4) @(negedge clk);
    chk("t6_post_rst", 64'({busy_o, req, we}), 64'd0);
    chk("t6_no_write", 64'((n_wr - wr0) + (n_bad_wr - bad0)), 64'd0);

    // Randomised streams of digits, line ends and junk.
    for (int t = 0; t < 14; t++) begin
      len = $urandom_range(13, 1);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(99);
        if (r < 80) byte_mem[i] = 8'h30 + 8'($urandom_range(9));
        else if (r < 88) byte_mem[i] = ($urandom_range(1) != 0) ? 8'h0a : 8'h0d;
        else byte_mem[i] = 8'h41 + 8'($urandom_range(25));
      end
      commit_bytes(len);
      run("rnd");
    end

    chk("bad_writes", 64'(n_bad_wr), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_rx.md
Name: sid_rx

Overview:
- Bus-master reader that receives an ASCII student-ID string from the UART peripheral. It is the receive-side counterpart of the sID transmit sequencer.
- When ex issues start_i, the block polls UART_STATUS through rib, reads each received byte from UART_RXDATA, and clears the rx flag.
- It packs the ASCII digits into BCD and compares the result with the expected ID.
- It returns done, busy, result and match/error status to ex.

Parameters:
- UART_BASE, 32'h3000_0000, UART base address; STATUS = base+4, RXDATA = base+16.
- DEPTH, 10, maximum number of digits accepted.
- EXP_BCD, 40'h20233_10655, expected ID in BCD. Width is 4*DEPTH.
- TIMEOUT, 32'd100000, maximum number of POLL cycles waiting for the next byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (`RstEnable = 0)
- start_i  in  1  one-cycle start request from ex
- done_o  out  1  one-cycle pulse when a receive finishes
- busy_o  out  1  high whenever state != IDLE
- bcd_o  out  4*DEPTH  received digits in BCD; the newest digit is in bits [3:0]
- cnt_o  out  4  number of digits received
- match_o  out  1  received string equals EXP_BCD
- err_o  out  1  timeout, or an illegal character was received
- rx_mem_req_o  out  1  bus request to rib
- rx_mem_we_o  out  1  write enable (`WriteEnable / `WriteDisable)
- rx_mem_addr_o  out  32  bus address
- rx_mem_wdata_o  out  32  bus write data
- rx_mem_gnt_i  in  1  rib grant; a transfer completes in any cycle where req and gnt are both high
- rx_mem_rdata_i  in  32  read data, combinational, valid in the granted cycle

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All outputs 0: bcd_o = 0, cnt_o = 0, match_o = 0, err_o = 0, done_o = 0, req = 0, we = 0, addr = 0, wdata = 0.
  - The timeout counter is cleared.
  - Reset asserted mid-transfer aborts immediately. No partial bus write is issued after reset deasserts.
- States:
  - IDLE: req = 0. When start_i = 1, clear bcd, cnt, err, match and the timeout counter, then go to POLL. Results from the previous run are held until then.
  - POLL: req = 1, we = 0, addr = STATUS.
    - On gnt with rdata[1] = 1 (rx received): go to READ and clear the timeout counter.
    - Otherwise: increment the timeout counter. When it reaches TIMEOUT, set err and go to DONE.
    - Cycles without gnt also count toward the timeout.
  - READ: req = 1, we = 0, addr = RXDATA. On gnt, let b = rdata[7:0]:
    - b in 0x30..0x39: bcd <= {bcd[4*DEPTH-5:0], b[3:0]}, cnt++.
    - b = 0x0A or 0x0D with cnt > 0: latch a terminate flag.
    - b = 0x0A or 0x0D with cnt = 0: ignore the byte (leading line end).
    - Any other byte: set err (sticky) and discard the byte.
    - Then go to CLEAR.
  - CLEAR: req = 1, we = 1, addr = STATUS, wdata = 0 (clears the rx flag). On gnt:
    - If the terminate flag is set or cnt == DEPTH, go to DONE.
    - Otherwise go to POLL.
  - DONE: one cycle. done_o = 1, match_o = (!err && cnt == DEPTH && bcd == EXP_BCD). Then go to IDLE.
- Request hold: req stays high until gnt arrives. Address and data are held stable while waiting.
- Latency: the minimum per byte is 3 cycles (POLL, READ, CLEAR), plus one DONE cycle.
- start_i while busy is ignored. start_i in the DONE cycle is also ignored; it is only accepted in IDLE.
- cnt saturates at DEPTH; a DEPTH-th digit forces termination after CLEAR.
- Width rules:
  - bcd is exactly 4*DEPTH bits.
  - A short string (terminated before DEPTH digits) is right-aligned with zero upper nibbles. match_o = 0 in that case.
- err and match are mutually exclusive: err = 1 forces match_o = 0.

Test Plan:
1. start_i, UART model supplies "2023310655" → exactly 10 POLL→READ→CLEAR sequences; done_o pulses once; bcd_o = 40'h2023310655, cnt_o = 10, match_o = 1, err_o = 0; 10 writes of 0 to 0x3000_0004.
2. Supply "2023310654" → bcd_o = 40'h2023310654, match_o = 0, err_o = 0.
3. Supply "12\n" → terminates after 3 bytes; cnt_o = 2, bcd_o = 40'h12, match_o = 0, done_o pulses.
4. Supply "20A23310655" with DEPTH = 10 → err_o = 1, 'A' discarded, cnt_o = 10, match_o = 0.
5. No RX data, TIMEOUT = 50 → done_o pulses after exactly 50 POLL cycles; err_o = 1, cnt_o = 0.
6. rx_mem_gnt_i held low for 5 cycles in READ → req, addr and we stable throughout. A start_i pulse while busy has no effect. rst low mid-CLEAR → all outputs 0 next edge, then IDLE.
